// File: rtl/gpu_bank_arbiter_pkg.sv
// gpu_pkg: shared widths and address helpers for the gpu_bank register file
// (8 contexts x 32 registers x 64 bits) and its round-robin bank arbiter.
package gpu_pkg;

    localparam int DATA_W       = 64;
    localparam int CTX_W        = 3;
    localparam int REG_W        = 5;
    localparam int NUM_CTX      = 8;
    localparam int REGS_PER_CTX = 32;

    // Flat bank address: context id in the upper bits, register index below.
    typedef logic [CTX_W+REG_W-1:0] bank_addr_t;

    // Builds the flat address ctx*REGS_PER_CTX + reg.
    function automatic bank_addr_t flat_addr(input logic [CTX_W-1:0] ctx_id,
                                             input logic [REG_W-1:0] reg_idx);
        return {ctx_id, reg_idx};
    endfunction

endpackage

// File: rtl/gpu_bank_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin pick. Returns the first
// eligible requester at or after ptr (wrapping) as a one-hot vector plus a
// found flag. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               found
);

    logic [PTR_W:0]   slot;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr and keep the first eligible one.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        slot   = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, ptr} + (PTR_W+1)'(k);
            if (slot >= (PTR_W+1)'(NUM_REQ)) begin
                slot = slot - (PTR_W+1)'(NUM_REQ);
            end
            idx = slot[PTR_W-1:0];
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_bank_arbiter.sv
// gpu_bank_arbiter: shares the single gpu_bank port between NUM_REQ
// requesters with round-robin priority. One access per cycle; read data
// returns to the granted requester three cycles after its request is
// sampled. Data/context/register widths come from gpu_pkg.
// Optional build macro GPU_BANK_ARB_STATS_EN adds a saturating stall_cnt.
module gpu_bank_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*CTX_W-1:0]  req_ctx,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      bank_read,
    output logic                      bank_write,
    output bank_addr_t                bank_addr,
    output logic [DATA_W-1:0]         bank_wdata,
    input  logic [DATA_W-1:0]         bank_rdata
`ifdef GPU_BANK_ARB_STATS_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               sel_we;
    logic [CTX_W-1:0]   sel_ctx;
    logic [REG_W-1:0]   sel_reg;
    logic [DATA_W-1:0]  sel_wdata;

    // Read tag pipeline: stage 1 travels with bank_read, stage 2 with bank_rdata.
    logic               tag1_valid;
    logic [PTR_W-1:0]   tag1_idx;
    logic               tag2_valid;
    logic [PTR_W-1:0]   tag2_idx;

    // A requester already holding gnt is skipped so a held req is not granted twice.
    assign eligible = req & ~gnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (win_oh),
        .found    (win_found)
    );

    // Encode the one-hot winner and mux out its command fields.
    always_comb begin
        win_idx   = '0;
        sel_we    = 1'b0;
        sel_ctx   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx   = PTR_W'(i);
                sel_we    = req_we[i];
                sel_ctx   = req_ctx[i*CTX_W +: CTX_W];
                sel_reg   = req_reg[i*REG_W +: REG_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

    // Register the grant, bank command and pointer; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            bank_read  <= 1'b0;
            bank_write <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            ptr        <= '0;
        end else begin
            gnt        <= win_oh;
            bank_read  <= win_found & ~sel_we;
            bank_write <= win_found & sel_we;
            if (win_found) begin
                bank_addr  <= flat_addr(sel_ctx, sel_reg);
                bank_wdata <= sel_wdata;
                ptr        <= ptr_next;
            end
        end
    end

    // Shift the read tag alongside the bank access so returns find their owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1_valid <= 1'b0;
            tag1_idx   <= '0;
            tag2_valid <= 1'b0;
            tag2_idx   <= '0;
        end else begin
            tag1_valid <= win_found & ~sel_we;
            tag1_idx   <= win_idx;
            tag2_valid <= tag1_valid;
            tag2_idx   <= tag1_idx;
        end
    end

    // Capture bank read data and pulse rvalid to the tagged requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag2_valid) begin
                rvalid[tag2_idx] <= 1'b1;
                rdata            <= bank_rdata;
            end
        end
    end

`ifdef GPU_BANK_ARB_STATS_EN
    logic stall_hit;

    // A cycle stalls when some eligible requester other than the winner waits.
    assign stall_hit = |(eligible & ~win_oh);

    // Count stalled cycles, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/gpu_bank_arbiter.md
Name: gpu_bank_arbiter

Overview:
Round-robin arbiter that shares one gpu_bank register file (8 contexts x 32 regs x 64 bit) between NUM_REQ requesters (warp/thread slots).
Forms the flat bank address {ctx, reg} and issues at most one read or write per cycle.
Returns read data to the granted requester with a fixed, known latency.
Sits between the warp schedulers and the bank; it is the only driver of the bank port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 64, register width
CTX_W, 3, context-id width (8 contexts)
REG_W, 5, register index width (32 regs per context)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request, held until granted
req_we  in  NUM_REQ  1 = write, 0 = read
req_ctx  in  NUM_REQ*CTX_W  context id, packed, requester i at [i*CTX_W +: CTX_W]
req_reg  in  NUM_REQ*REG_W  register index, packed likewise
req_wdata  in  NUM_REQ*DATA_W  write data, packed likewise
gnt  out  NUM_REQ  one-hot grant pulse, registered
rvalid  out  NUM_REQ  one-hot read-data-valid pulse, registered
rdata  out  DATA_W  read data, valid while any rvalid bit is high
bank_read  out  1  bank read strobe
bank_write  out  1  bank write strobe
bank_addr  out  CTX_W+REG_W  {ctx, reg} flat address (ctx*32 + reg)
bank_wdata  out  DATA_W  bank write data
bank_rdata  in  DATA_W  bank read data, valid 1 cycle after bank_read

Behaviour:
- Reset (async, active-high) clears: gnt, rvalid, rdata, bank_read, bank_write, bank_addr, bank_wdata = 0; round-robin pointer = 0 (requester 0 has top priority first).
- Arbitration in cycle t:
  - Eligible set = req & ~gnt. A requester whose gnt is high this cycle is excluded, so a held req is never granted twice.
  - Winner is the first eligible index at or after ptr, wrapping modulo NUM_REQ.
- On the edge ending cycle t, with winner w:
  - gnt = onehot(w).
  - bank_addr = {req_ctx[w], req_reg[w]}.
  - bank_wdata = req_wdata[w].
  - bank_write = req_we[w]; bank_read = ~req_we[w].
  - ptr = (w+1) mod NUM_REQ.
- With no eligible requester: gnt = 0, both strobes = 0, ptr unchanged. bank_addr and bank_wdata hold their last values.
- bank_read and bank_write are never high together. At most one gnt bit is high.
- Requester handshake: the requester sees gnt[i] in cycle t+1 and must drop or replace req[i] by the end of t+1.
- Read pipeline:
  - bank_read in cycle t+1 gives bank_rdata valid in t+2.
  - Controller registers it, so rvalid[w] = 1 and rdata = bank_rdata in cycle t+3.
  - Read latency from req sampled to rvalid is 3 cycles. Throughput is 1 access/cycle.
- Pipeline tag: a read tag (valid, index) shifts through two registers alongside the bank access. Writes produce no rvalid.
- Ordering: a write granted in cycle t followed by a read of the same address granted in t+1 returns the new data. The bank writes at the end of t+1 and reads at the end of t+2, so no forwarding is needed.
- rdata holds its last value when rvalid = 0.
- Reset mid-operation flushes in-flight tags: no rvalid is produced for reads issued before reset.

Optional Feature:
GPU_BANK_ARB_STATS_EN
- Defined: adds output stall_cnt (32 bits).
  - Increments every cycle in which the eligible set has a bit that does not win; one count per cycle, not per requester.
  - Saturates at 0xFFFF_FFFF. Cleared by rst.
- Undefined: port and counter are absent; no other change.

Decomposition:
- Package gpu_pkg: DATA_W, CTX_W, REG_W, NUM_CTX = 8, REGS_PER_CTX = 32, and a typedef bank_addr_t = logic [CTX_W+REG_W-1:0].
- Sub-module rr_arbiter: NUM_REQ-wide, inputs eligible and ptr, outputs one-hot winner and a found flag. Purely combinational; the pointer register stays in gpu_bank_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulsed mid-cycle (async), req = 0.
  - Response: all outputs 0 immediately and afterwards; stall_cnt = 0.
- Single write then read:
  - Stimulus: req0 writes ctx=2, reg=5, data 0xDEAD_BEEF_0123_4567, then the same address is read.
  - Response: bank_addr = 69 for both; the read gives rvalid[0] 3 cycles after its req with rdata = 0xDEAD_BEEF_0123_4567.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold reads (each re-asserts after gnt).
  - Response: grant order 0,1,2,3,0,1 and so on; gnt is never back-to-back to the same index.
- Wrap and skip:
  - Stimulus: ptr = 3 with only req1 and req3 high.
  - Response: req3 is granted first, then req1; ptr goes to 0, then 2.
- Back-to-back RAW:
  - Stimulus: req2 write reg 7 = 0x55 granted in cycle t; req3 read of reg 7 granted in t+1.
  - Response: rvalid[3] with rdata = 0x55.
- Reset with reads in flight:
  - Stimulus: two reads granted, rst asserted before their rvalid.
  - Response: no rvalid ever appears for them; ptr = 0 after release.
